// File: rtl/time_ascii_formatter_pkg.sv
// Shared definitions for the stopwatch ASCII frame formatter: FSM encoding,
// frame geometry and the ASCII constants used to build "CR MM:SS.HH".
package time_ascii_formatter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int FRAME_LEN = 9;
    localparam int LAST_IDX  = FRAME_LEN - 1;

    localparam logic [7:0] LEAD_CHAR_DEFAULT = 8'h0D;
    localparam logic [7:0] ASCII_COLON       = 8'h3A;
    localparam logic [7:0] ASCII_DOT         = 8'h2E;
    localparam logic [7:0] ASCII_ZERO        = 8'h30;

    // All ones never matches a legal time, so the first frame after reset is always sent.
    localparam logic [29:0] LAST_SENT_INIT = 30'h3FFF_FFFF;

    function automatic logic [7:0] digit_ascii(input logic [3:0] digit);
        return ASCII_ZERO + {4'h0, digit};
    endfunction

endpackage

// File: rtl/time_ascii_formatter_bin2dec2.sv
// Combinational binary to two-digit decimal converter; values above 99
// saturate so an out-of-range field is shown as "99".
module bin2dec2
    import time_ascii_formatter_pkg::*;
(
    input  logic [9:0] value,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [6:0] clamped;

    always_comb begin
        clamped = (value > 10'd99) ? 7'd99 : value[6:0];
        tens    = 4'(clamped / 7'd10);
        ones    = 4'(clamped % 7'd10);
    end

endmodule

// File: rtl/time_ascii_formatter.sv
// Snapshots the stopwatch time and streams it as the 9-byte frame
// "CR MM:SS.HH" over a valid/ready byte interface whenever the time changes.
module time_ascii_formatter
    import time_ascii_formatter_pkg::*;
#(
    parameter logic [7:0] LEAD_CHAR = LEAD_CHAR_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] minutes,
    input  logic [9:0] seconds,
    input  logic [9:0] hundreth_sec,
    input  logic       force_send,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic       frame_done
);

    state_t         state_reg, state_next;
    logic [3:0]     byte_idx_reg, byte_idx_next;
    logic [29:0]    last_sent_reg, last_sent_next;
    logic [29:0]    snap_reg, snap_next;
    logic [5:0][3:0] digits_reg, digits_next;
    logic           force_pending_reg, force_pending_next;

    logic [29:0]    time_now;
    logic [9:0]     field_in [3];
    logic [3:0]     tens_w   [3];
    logic [3:0]     ones_w   [3];
    logic [7:0]     byte_sel;

    assign time_now    = {minutes, seconds, hundreth_sec};
    assign field_in[0] = minutes;
    assign field_in[1] = seconds;
    assign field_in[2] = hundreth_sec;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_conv
            bin2dec2 u_bin2dec2 (
                .value (field_in[gi]),
                .tens  (tens_w[gi]),
                .ones  (ones_w[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= ST_IDLE;
            byte_idx_reg      <= 4'd0;
            last_sent_reg     <= LAST_SENT_INIT;
            snap_reg          <= '0;
            digits_reg        <= '0;
            force_pending_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            byte_idx_reg      <= byte_idx_next;
            last_sent_reg     <= last_sent_next;
            snap_reg          <= snap_next;
            digits_reg        <= digits_next;
            force_pending_reg <= force_pending_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        byte_idx_next      = byte_idx_reg;
        last_sent_next     = last_sent_reg;
        snap_next          = snap_reg;
        digits_next        = digits_reg;
        force_pending_next = force_pending_reg;

        case (state_reg)
            ST_IDLE: begin
                if (force_send || force_pending_reg || (time_now != last_sent_reg))
                    state_next = ST_LOAD;
            end
            ST_LOAD: begin
                snap_next = time_now;
                for (int i = 0; i < 3; i++) begin
                    digits_next[2*i]   = tens_w[i];
                    digits_next[2*i+1] = ones_w[i];
                end
                byte_idx_next = 4'd0;
                if (force_send)
                    force_pending_next = 1'b1;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (force_send)
                    force_pending_next = 1'b1;
                // tx_valid is always high here, so tx_ready alone marks a transfer.
                if (tx_ready) begin
                    if (byte_idx_reg == 4'(LAST_IDX))
                        state_next = ST_DONE;
                    else
                        byte_idx_next = byte_idx_reg + 4'd1;
                end
            end
            ST_DONE: begin
                last_sent_next     = snap_reg;
                force_pending_next = force_send;
                state_next         = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        case (byte_idx_reg)
            4'd0:    byte_sel = LEAD_CHAR;
            4'd1:    byte_sel = digit_ascii(digits_reg[0]);
            4'd2:    byte_sel = digit_ascii(digits_reg[1]);
            4'd3:    byte_sel = ASCII_COLON;
            4'd4:    byte_sel = digit_ascii(digits_reg[2]);
            4'd5:    byte_sel = digit_ascii(digits_reg[3]);
            4'd6:    byte_sel = ASCII_DOT;
            4'd7:    byte_sel = digit_ascii(digits_reg[4]);
            4'd8:    byte_sel = digit_ascii(digits_reg[5]);
            default: byte_sel = 8'h00;
        endcase
    end

    // Outputs decode registered state only, so reset clears them at once.
    assign tx_valid   = (state_reg == ST_SEND);
    assign tx_data    = tx_valid ? byte_sel : 8'h00;
    assign busy       = (state_reg != ST_IDLE);
    assign frame_done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_time_ascii_formatter.sv
// Self-checking bench for time_ascii_formatter: table vectors, random frames
// against a text-level reference model, and hand-written corner sequences.
module tb_time_ascii_formatter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] minutes = '0;
    logic [9:0] seconds = '0;
    logic [9:0] hundreth_sec = '0;
    logic       force_send = 1'b0;
    logic       tx_ready = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       busy;
    logic       frame_done;

    int errors = 0;
    int checks = 0;
    logic [7:0] rx_q [$];

    typedef struct {
        int          m;
        int          s;
        int          h;
        bit          frc;
        int          pct;
        logic [63:0] txt;
    } vec_t;

    vec_t tbl [8];

    time_ascii_formatter dut (
        .clk          (clk),
        .reset        (reset),
        .minutes      (minutes),
        .seconds      (seconds),
        .hundreth_sec (hundreth_sec),
        .force_send   (force_send),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // Reference: the displayed text "MM:SS.HH" straight from decimal arithmetic.
    function automatic logic [63:0] model_text(input int m, input int s, input int h);
        int v [3];
        v[0] = (m > 99) ? 99 : m;
        v[1] = (s > 99) ? 99 : s;
        v[2] = (h > 99) ? 99 : h;
        return {8'(48 + v[0] / 10), 8'(48 + v[0] % 10), ":",
                8'(48 + v[1] / 10), 8'(48 + v[1] % 10), ".",
                8'(48 + v[2] / 10), 8'(48 + v[2] % 10)};
    endfunction

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Advance one clock; log any transfer happening on this edge and verify stall stability.
    task automatic step();
        logic       stall;
        logic [7:0] held;
        stall = tx_valid && !tx_ready;
        held  = tx_data;
        if (tx_valid && tx_ready)
            rx_q.push_back(tx_data);
        @(posedge clk);
        #1;
        if (stall && reset) begin
            check_eq("stall_valid", 64'(tx_valid), 64'(1));
            check_eq("stall_data", 64'(tx_data), 64'(held));
        end
    endtask

    task automatic run_frame(input string name, input int m, input int s, input int h,
                             input bit frc, input int pct, input logic [63:0] txt,
                             input int mid_at, input int mm, input int ms, input int mh);
        int          ncyc;
        int          first_valid;
        bit          done;
        logic [7:0]  exp_b;
        logic [7:0]  got_b;
        minutes      = 10'(m);
        seconds      = 10'(s);
        hundreth_sec = 10'(h);
        rx_q.delete();
        ncyc = 0;
        first_valid = -1;
        done = 1'b0;
        while (!done && ncyc < 300) begin
            force_send = frc && (ncyc == 0);
            if (ncyc == mid_at) begin
                minutes      = 10'(mm);
                seconds      = 10'(ms);
                hundreth_sec = 10'(mh);
            end
            tx_ready = ($urandom_range(0, 99) < pct);
            step();
            force_send = 1'b0;
            ncyc++;
            if (tx_valid && first_valid < 0)
                first_valid = ncyc;
            if (frame_done)
                done = 1'b1;
        end
        $display("frame %s: bytes=%0d first_valid=%0d cycles=%0d text=%s",
                 name, rx_q.size(), first_valid, ncyc, txt);
        check_eq({name, "_timeout"}, 64'(done), 64'(1));
        check_eq({name, "_latency"}, 64'(first_valid), 64'(2));
        check_eq({name, "_len"}, 64'(rx_q.size()), 64'(9));
        if (pct >= 100)
            check_eq({name, "_duration"}, 64'(ncyc), 64'(11));
        for (int i = 0; i < 9; i++) begin
            exp_b = (i == 0) ? 8'h0D : txt[71 - 8*i -: 8];
            got_b = (i < rx_q.size()) ? rx_q[i] : 8'h00;
            check_eq($sformatf("%s_byte%0d", name, i), 64'(got_b), 64'(exp_b));
        end
        tx_ready = 1'b1;
        step();
        check_eq({name, "_idle_busy"}, 64'(busy), 64'(0));
        check_eq({name, "_done_pulse"}, 64'(frame_done), 64'(0));
    endtask

    initial begin
        int nvalid;
        int cnt;
        int rm, rs, rh, pct;
        int pm, ps, ph;

        tbl[0] = '{12, 34, 56, 1'b0, 100, "12:34.56"};
        tbl[1] = '{12, 34, 56, 1'b1, 100, "12:34.56"};
        tbl[2] = '{0, 0, 0, 1'b0, 100, "00:00.00"};
        tbl[3] = '{59, 59, 99, 1'b0, 60, "59:59.99"};
        tbl[4] = '{59, 59, 150, 1'b0, 50, "59:59.99"};
        tbl[5] = '{7, 5, 9, 1'b0, 40, "07:05.09"};
        tbl[6] = '{100, 200, 1023, 1'b0, 100, "99:99.99"};
        tbl[7] = '{59, 0, 1, 1'b0, 70, "59:00.01"};

        minutes = 10'd12;
        seconds = 10'd34;
        hundreth_sec = 10'd56;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tx_data", 64'(tx_data), 64'(0));
        check_eq("rst_tx_valid", 64'(tx_valid), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_frame_done", 64'(frame_done), 64'(0));
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_frame($sformatf("tbl%0d", i), tbl[i].m, tbl[i].s, tbl[i].h,
                      tbl[i].frc, tbl[i].pct, tbl[i].txt, -1, 0, 0, 0);
            if (i == 0) begin
                nvalid = 0;
                for (int k = 0; k < 20; k++) begin
                    tx_ready = 1'b1;
                    step();
                    if (tx_valid || busy) nvalid++;
                end
                $display("idle hold: active_cycles=%0d", nvalid);
                check_eq("idle_no_resend", 64'(nvalid), 64'(0));
            end
        end
        pm = 59; ps = 0; ph = 1;

        for (int i = 0; i < 16; i++) begin
            rm  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 59);
            rs  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 59);
            rh  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 99);
            pct = $urandom_range(20, 100);
            run_frame($sformatf("rnd%0d", i), rm, rs, rh,
                      (rm == pm && rs == ps && rh == ph), pct, model_text(rm, rs, rh), -1, 0, 0, 0);
            pm = rm; ps = rs; ph = rh;
        end

        run_frame("mid_old", 1, 2, 3, 1'b1, 50, model_text(1, 2, 3), 6, 4, 5, 6);
        run_frame("mid_new", 4, 5, 6, 1'b0, 100, model_text(4, 5, 6), -1, 0, 0, 0);

        // Abort a frame with reset while byte 4 is on the bus.
        minutes = 10'd21;
        seconds = 10'd43;
        hundreth_sec = 10'd65;
        rx_q.delete();
        cnt = 0;
        while (rx_q.size() < 4 && cnt < 100) begin
            force_send = (cnt == 0);
            tx_ready = 1'b1;
            step();
            force_send = 1'b0;
            cnt++;
        end
        check_eq("abort_reach_byte4", 64'(rx_q.size()), 64'(4));
        reset = 1'b0;
        #1;
        $display("reset mid-frame: tx_valid=%0b busy=%0b tx_data=%0h", tx_valid, busy, tx_data);
        check_eq("abort_tx_valid", 64'(tx_valid), 64'(0));
        check_eq("abort_busy", 64'(busy), 64'(0));
        check_eq("abort_tx_data", 64'(tx_data), 64'(0));
        repeat (2) step();
        reset = 1'b1;
        run_frame("after_abort", 21, 43, 65, 1'b0, 100, model_text(21, 43, 65), -1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
